decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
Parametrised, registered successor to the combinational decode controller. It decodes a 32-bit RV32I/M instruction into the control bundle and holds it in an output register (the ID/EX control slot) with a valid/ready handshake and flush. It also performs strict func3/func7 legality checks, detects load-use hazards and inserts a bubble, and optionally counts illegal instructions. It sits between IF/ID and the execute stage.

Parameters:
M_EXT, 1, 1 = accept M-extension ops (func7=0000001 on opcode 0110011); 0 = flag them invalid
STRICT, 1, 1 = full func3/func7 legality checks; 0 = opcode-only legality
CNT_W, 16, width of the illegal-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction available from IF/ID
in_ready  out  1  instruction accepted this cycle
in_instr  in  32  instruction word
flush  in  1  kill the held bundle; block input this cycle
out_valid  out  1  control bundle valid
out_ready  in  1  EX consumes the bundle
out_alu_src  out  1  immediate operand select
out_mem_write  out  1  store
out_mem_load_type  out  3  load func3
out_mem_store_type  out  2  00=byte, 01=half, 10=word, 11=no write
out_wb_load  out  1  load writeback
out_wb_reg_file  out  1  register-file write
out_m_type  out  1  M-extension op
out_branch  out  1  B-type
out_jal  out  1  JAL
out_jalr  out  1  JALR
out_rd  out  5  destination register
out_rs1  out  5  source register 1
out_rs2  out  5  source register 2
out_invalid  out  1  illegal instruction
hazard_stall  out  1  load-use stall active
illegal_count  out  CNT_W  saturating count of illegal instructions retired to EX

Behaviour:
- Reset: when rst_n=0 at a clk edge, every out_* register is cleared to 0, except out_mem_store_type=11. illegal_count is cleared to 0.
- Latency: 1 cycle. An instruction accepted at edge N is presented with out_valid=1 after edge N.
- load_use = out_valid & out_wb_load & (out_rd!=0) & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
  - uses_rs1 holds for R, I-ALU, load, store, branch and JALR.
  - uses_rs2 holds for R, store and branch.
- hazard_stall = in_valid & load_use.
- in_ready = !flush & !load_use & (!out_valid | out_ready).
- Edge update priority:
  1. flush: out_valid <- 0.
  2. in_valid & in_ready: load the decoded bundle, out_valid <- 1.
  3. out_ready: out_valid <- 0. On a load_use cycle this creates the bubble.
  4. Otherwise hold. The bundle stays stable while out_valid & !out_ready.
- Legality when STRICT=1:
  - R: func7 is 0000000, or 0100000 only with func3 000/101, or 0000001 only with M_EXT=1.
  - Loads: func3 is 000, 001, 010, 100 or 101.
  - Stores: func3 is 000, 001 or 010.
  - Branches: func3 is not 010/011.
  - JALR: func3 is 000.
  - Shifts (I-ALU func3 001/101): func7 is 0000000, or 0100000 only with func3 101.
  - LUI, AUIPC and JAL are legal.
  - Any other opcode is illegal.
- Legality when STRICT=0: opcode-only, plus the M_EXT check.
- An illegal instruction sets out_invalid=1 and forces out_mem_write, out_wb_load, out_wb_reg_file and out_m_type to 0, and out_mem_store_type to 11.
- out_wb_reg_file=0 when rd=0.
- out_mem_load_type = func3 for loads, else 000.
- Counter: increments on out_valid & out_ready & out_invalid and saturates at all ones. A flushed bundle is never counted.
- Flush while the bundle is stalled discards it. Reset mid-stall clears everything; no pending state survives.

Optional Feature:
DECODE_ILLEGAL_CNT_EN
- Defined: the counter register exists and behaves as above.
- Undefined: no counter register; illegal_count is tied to 0. All other behaviour is unchanged.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - store encodings ST_B, ST_H, ST_W, ST_NONE;
  - func7 constants.
- Sub-module decode_logic: purely combinational instr -> bundle + invalid + uses_rs1/uses_rs2, parametrised by M_EXT/STRICT.
- The top level owns the register, handshake, hazard logic and counter.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> out_valid=1 next cycle; wb_reg_file=1, alu_src=0, rd=3, invalid=0.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> hazard_stall=1 for 1 cycle; in_ready=0; one out_valid=0 bubble; ADD appears 2 cycles after LW.
- SH with func3=011 (STRICT=1) -> invalid=1, mem_write=0, store_type=11; illegal_count 0->1 on handshake.
- MUL (func7=0000001) with M_EXT=0 -> invalid=1; with M_EXT=1 -> m_type=1, wb_reg_file=1.
- out_ready=0 for 3 cycles holding SW -> bundle stable, in_ready=0; then flush=1 -> out_valid=0 next cycle, illegal_count unchanged.
- CNT_W=2, four illegal instructions retired -> illegal_count saturates at 3.

Source files
------------

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the registered RV32I/M decode controller:
//   - RV32 major opcodes handled by the decoder
//   - store-size encodings carried on out_mem_store_type
//   - func7 values that select base, alternate (SUB/SRA) and M-extension ops
//   - ctrl_t, the control bundle held in the ID/EX slot, and its reset value
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ST_B    = 2'b00;
    localparam logic [1:0] ST_H    = 2'b01;
    localparam logic [1:0] ST_W    = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] mem_load_type;
        logic [1:0] mem_store_type;
        logic       wb_load;
        logic       wb_reg_file;
        logic       m_type;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       invalid;
    } ctrl_t;

    // Idle bundle: everything off, and "no write" on the store-size field.
    localparam ctrl_t CTRL_RESET = '{
        alu_src:        1'b0,
        mem_write:      1'b0,
        mem_load_type:  3'b000,
        mem_store_type: ST_NONE,
        wb_load:        1'b0,
        wb_reg_file:    1'b0,
        m_type:         1'b0,
        branch:         1'b0,
        jal:            1'b0,
        jalr:           1'b0,
        rd:             5'd0,
        rs1:            5'd0,
        rs2:            5'd0,
        invalid:        1'b0
    };

endpackage

// File: rtl/decode_ctrl_pipe_logic.sv
// -----------------------------------------------------------------------------
// decode_logic
// Purely combinational RV32I/M instruction decoder.
//   instr    in  32  instruction word
//   ctrl     out     decoded control bundle (ctrl_t), including invalid flag
//   uses_rs1 out  1  instruction reads rs1 (R, I-ALU, load, store, branch, JALR)
//   uses_rs2 out  1  instruction reads rs2 (R, store, branch)
// Parameters:
//   M_EXT  1 = accept MUL/DIV (func7=0000001 on OP_R), 0 = flag them illegal
//   STRICT 1 = full func3/func7 legality, 0 = opcode-only legality (+ M_EXT)
// An illegal instruction keeps its branch/jump flags and register fields but
// has every architectural side effect (memory write, writeback, M op) removed.
// -----------------------------------------------------------------------------
module decode_logic
    import decode_pkg::*;
#(
    parameter bit M_EXT  = 1'b1,
    parameter bit STRICT = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [6:0] func7;
    logic [2:0] func3;
    logic       strict_ok;
    logic       base_ok;
    logic       writes_rd;
    logic       legal;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];

    always_comb begin
        // NOTE: every output and temporary gets a default before the case, so
        // no opcode path can leave one unassigned and infer a latch.
        ctrl          = CTRL_RESET;
        ctrl.rd       = instr[11:7];
        ctrl.rs1      = instr[19:15];
        ctrl.rs2      = instr[24:20];
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        writes_rd     = 1'b0;
        strict_ok     = 1'b0;
        base_ok       = 1'b1;

        case (opcode)
            OP_R: begin
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                writes_rd   = 1'b1;
                ctrl.m_type = (func7 == F7_MULDIV);
                base_ok     = (func7 != F7_MULDIV) || M_EXT;
                strict_ok   = (func7 == F7_BASE)
                           || (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101))
                           || (func7 == F7_MULDIV && M_EXT);
            end
            OP_IMM: begin
                uses_rs1     = 1'b1;
                writes_rd    = 1'b1;
                ctrl.alu_src = 1'b1;
                // Only the shift immediates carry a func7 field.
                case (func3)
                    3'b001:  strict_ok = (func7 == F7_BASE);
                    3'b101:  strict_ok = (func7 == F7_BASE) || (func7 == F7_ALT);
                    default: strict_ok = 1'b1;
                endcase
            end
            OP_LOAD: begin
                uses_rs1           = 1'b1;
                writes_rd          = 1'b1;
                ctrl.alu_src       = 1'b1;
                ctrl.wb_load       = 1'b1;
                ctrl.mem_load_type = func3;
                strict_ok = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OP_STORE: begin
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
                ctrl.alu_src        = 1'b1;
                ctrl.mem_write      = 1'b1;
                ctrl.mem_store_type = func3[1:0];
                strict_ok = func3 inside {3'b000, 3'b001, 3'b010};
            end
            OP_BRANCH: begin
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                ctrl.branch = 1'b1;
                strict_ok   = !(func3 inside {3'b010, 3'b011});
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                ctrl.jal  = 1'b1;
                strict_ok = 1'b1;
            end
            OP_JALR: begin
                uses_rs1     = 1'b1;
                writes_rd    = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.jalr    = 1'b1;
                strict_ok    = (func3 == 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                writes_rd    = 1'b1;
                ctrl.alu_src = 1'b1;
                strict_ok    = 1'b1;
            end
            default: begin
                base_ok = 1'b0;
            end
        endcase

        legal            = STRICT ? strict_ok : base_ok;
        ctrl.wb_reg_file = writes_rd && (ctrl.rd != 5'd0);

        if (!legal) begin
            ctrl.invalid        = 1'b1;
            ctrl.mem_write      = 1'b0;
            ctrl.wb_load        = 1'b0;
            ctrl.wb_reg_file    = 1'b0;
            ctrl.m_type         = 1'b0;
            ctrl.mem_store_type = ST_NONE;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe
// Registered RV32I/M decode stage: decodes the IF/ID instruction and holds the
// control bundle in the ID/EX slot behind a valid/ready handshake.
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  IF/ID handshake, in_instr is the instruction word
//   flush              kill the held bundle, refuse input this cycle
//   out_valid/out_ready ID/EX handshake for the out_* control bundle
//   hazard_stall       load-use stall active (in_valid blocked by a load)
//   illegal_count      saturating count of illegal bundles consumed by EX
// Parameters: M_EXT, STRICT (passed to decode_logic), CNT_W (counter width).
// Build option: define DECODE_ILLEGAL_CNT_EN to build the illegal-instruction
// counter; without it illegal_count is tied to zero.
// -----------------------------------------------------------------------------
module decode_ctrl_pipe
    import decode_pkg::*;
#(
    parameter bit M_EXT  = 1'b1,
    parameter bit STRICT = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_alu_src,
    output logic             out_mem_write,
    output logic [2:0]       out_mem_load_type,
    output logic [1:0]       out_mem_store_type,
    output logic             out_wb_load,
    output logic             out_wb_reg_file,
    output logic             out_m_type,
    output logic             out_branch,
    output logic             out_jal,
    output logic             out_jalr,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_invalid,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] illegal_count
);

    ctrl_t dec;
    logic  uses_rs1;
    logic  uses_rs2;
    ctrl_t ctrl_d, ctrl_q;
    logic  valid_d, valid_q;
    logic  load_use;
    logic  accept;

    decode_logic #(
        .M_EXT  (M_EXT),
        .STRICT (STRICT)
    ) u_decode (
        .instr    (in_instr),
        .ctrl     (dec),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // The held bundle is a load whose result the incoming instruction needs;
    // x0 is never a real dependency.
    assign load_use = valid_q && ctrl_q.wb_load && (ctrl_q.rd != 5'd0)
                   && ((uses_rs1 && dec.rs1 == ctrl_q.rd)
                    || (uses_rs2 && dec.rs2 == ctrl_q.rd));

    assign hazard_stall = in_valid && load_use;
    assign in_ready     = !flush && !load_use && (!valid_q || out_ready);
    assign accept       = in_valid && in_ready;

    // Slot update: flush beats a new load, which beats a plain drain. A drain
    // during a load-use cycle leaves the slot empty, which is the bubble.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples the pre-edge
        // values together; the reset branch restores the full bundle.
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RESET;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_count_d, illegal_count_q;
    logic             retire_illegal;

    // A bundle flushed in the same cycle never reaches EX, so it is not counted.
    assign retire_illegal = valid_q && out_ready && ctrl_q.invalid && !flush;

    always_comb begin
        illegal_count_d = illegal_count_q;
        if (retire_illegal && (illegal_count_q != {CNT_W{1'b1}})) begin
            illegal_count_d = illegal_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_count_q <= '0;
        end else begin
            illegal_count_q <= illegal_count_d;
        end
    end

    assign illegal_count = illegal_count_q;
`else
    assign illegal_count = '0;
`endif

    assign out_valid          = valid_q;
    assign out_alu_src        = ctrl_q.alu_src;
    assign out_mem_write      = ctrl_q.mem_write;
    assign out_mem_load_type  = ctrl_q.mem_load_type;
    assign out_mem_store_type = ctrl_q.mem_store_type;
    assign out_wb_load        = ctrl_q.wb_load;
    assign out_wb_reg_file    = ctrl_q.wb_reg_file;
    assign out_m_type         = ctrl_q.m_type;
    assign out_branch         = ctrl_q.branch;
    assign out_jal            = ctrl_q.jal;
    assign out_jalr           = ctrl_q.jalr;
    assign out_rd             = ctrl_q.rd;
    assign out_rs1            = ctrl_q.rs1;
    assign out_rs2            = ctrl_q.rs2;
    assign out_invalid        = ctrl_q.invalid;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_pipe
// Two decoder instances share one stimulus stream: dut a (M_EXT=1, CNT_W=16)
// and dut b (M_EXT=0, CNT_W=2, so its counter saturates at 3). A behavioural
// model of the ID/EX slot tracks each instance and a negedge process compares
// every output; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

`ifdef DECODE_ILLEGAL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       wb_load;
        logic       wb_reg;
        logic       m_type;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       invalid;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr;

    logic       in_ready [2];
    logic       out_valid [2];
    logic       out_alu_src [2];
    logic       out_mem_write [2];
    logic [2:0] out_mem_load_type [2];
    logic [1:0] out_mem_store_type [2];
    logic       out_wb_load [2];
    logic       out_wb_reg_file [2];
    logic       out_m_type [2];
    logic       out_branch [2];
    logic       out_jal [2];
    logic       out_jalr [2];
    logic [4:0] out_rd [2];
    logic [4:0] out_rs1 [2];
    logic [4:0] out_rs2 [2];
    logic       out_invalid [2];
    logic       hazard_stall [2];
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.M_EXT(1'b1), .STRICT(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_alu_src(out_alu_src[0]), .out_mem_write(out_mem_write[0]),
        .out_mem_load_type(out_mem_load_type[0]), .out_mem_store_type(out_mem_store_type[0]),
        .out_wb_load(out_wb_load[0]), .out_wb_reg_file(out_wb_reg_file[0]),
        .out_m_type(out_m_type[0]), .out_branch(out_branch[0]), .out_jal(out_jal[0]),
        .out_jalr(out_jalr[0]), .out_rd(out_rd[0]), .out_rs1(out_rs1[0]), .out_rs2(out_rs2[0]),
        .out_invalid(out_invalid[0]), .hazard_stall(hazard_stall[0]), .illegal_count(cnt_a)
    );

    decode_ctrl_pipe #(.M_EXT(1'b0), .STRICT(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_alu_src(out_alu_src[1]), .out_mem_write(out_mem_write[1]),
        .out_mem_load_type(out_mem_load_type[1]), .out_mem_store_type(out_mem_store_type[1]),
        .out_wb_load(out_wb_load[1]), .out_wb_reg_file(out_wb_reg_file[1]),
        .out_m_type(out_m_type[1]), .out_branch(out_branch[1]), .out_jal(out_jal[1]),
        .out_jalr(out_jalr[1]), .out_rd(out_rd[1]), .out_rs1(out_rs1[1]), .out_rs2(out_rs2[1]),
        .out_invalid(out_invalid[1]), .hazard_stall(hazard_stall[1]), .illegal_count(cnt_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit reads_rs1(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bundle_t idle_bundle();
        bundle_t b = '0;
        b.store_type = 2'b11;
        return b;
    endfunction

    // What the ID/EX slot must contain for an instruction, from the ISA rules.
    function automatic bundle_t model_decode(input logic [31:0] ins, input bit m_ext);
        bundle_t    b = idle_bundle();
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit ok = 0, has_rd = 0, is_load = 0, is_store = 0, is_mul = 0;
        b.rd  = ins[11:7];
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        case (ins[6:0])
            7'h33: begin  // register-register
                has_rd = 1; is_mul = (f7 == 7'h01);
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (is_mul && m_ext);
            end
            7'h13: begin  // immediate ALU
                has_rd = 1; b.alu_src = 1;
                if (f3 == 1) ok = (f7 == 7'h00);
                else if (f3 == 5) ok = (f7 == 7'h00 || f7 == 7'h20);
                else ok = 1;
            end
            7'h03: begin
                has_rd = 1; is_load = 1; b.alu_src = 1; b.load_type = f3;
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                is_store = 1; b.alu_src = 1; ok = (f3 <= 2);
            end
            7'h63: begin b.branch = 1; ok = !(f3 == 2 || f3 == 3); end
            7'h6F: begin b.jal = 1; has_rd = 1; ok = 1; end
            7'h67: begin b.jalr = 1; has_rd = 1; b.alu_src = 1; ok = (f3 == 0); end
            7'h37, 7'h17: begin has_rd = 1; b.alu_src = 1; ok = 1; end
            default: ok = 0;
        endcase
        b.invalid    = !ok;
        b.mem_write  = ok && is_store;
        b.store_type = (ok && is_store) ? f3[1:0] : 2'b11;
        b.wb_load    = ok && is_load;
        b.wb_reg     = ok && has_rd && (ins[11:7] != 0);
        b.m_type     = ok && is_mul;
        return b;
    endfunction

    function automatic bit model_load_use(input bit v, input bundle_t b, input logic [31:0] ins);
        return v && b.wb_load && (b.rd != 0)
            && ((reads_rs1(ins) && ins[19:15] == b.rd) || (reads_rs2(ins) && ins[24:20] == b.rd));
    endfunction

    bit      mv   [2];
    bundle_t mb   [2];
    int      mcnt [2];
    bit      mrst [2];
    bit      started = 0;

    function automatic int exp_count(input int k);
        int cap = (k == 0) ? 65535 : 3;
        if (!CNT_ON) return 0;
        return (mcnt[k] > cap) ? cap : mcnt[k];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mv[k] = 0; mb[k] = idle_bundle(); mcnt[k] = 0; mrst[k] = 1;
            end else begin
                bit rdy;
                rdy = !flush && !model_load_use(mv[k], mb[k], in_instr) && (!mv[k] || out_ready);
                if (mv[k] && out_ready && mb[k].invalid && !flush) mcnt[k]++;
                if (flush) mv[k] = 0;
                else if (in_valid && rdy) begin
                    mv[k] = 1; mb[k] = model_decode(in_instr, (k == 0)); mrst[k] = 0;
                end else if (out_ready) mv[k] = 0;
            end
        end
        started = 1;
    end

    // ---------------- compare process ----------------
    task automatic check_bundle(input string t, input int k, input bundle_t e);
        check({t, ".alu_src"},    out_alu_src[k],        e.alu_src);
        check({t, ".mem_write"},  out_mem_write[k],      e.mem_write);
        check({t, ".load_type"},  out_mem_load_type[k],  e.load_type);
        check({t, ".store_type"}, out_mem_store_type[k], e.store_type);
        check({t, ".wb_load"},    out_wb_load[k],        e.wb_load);
        check({t, ".wb_reg"},     out_wb_reg_file[k],    e.wb_reg);
        check({t, ".m_type"},     out_m_type[k],         e.m_type);
        check({t, ".branch"},     out_branch[k],         e.branch);
        check({t, ".jal"},        out_jal[k],            e.jal);
        check({t, ".jalr"},       out_jalr[k],           e.jalr);
        check({t, ".rd"},         out_rd[k],             e.rd);
        check({t, ".rs1"},        out_rs1[k],            e.rs1);
        check({t, ".rs2"},        out_rs2[k],            e.rs2);
        check({t, ".invalid"},    out_invalid[k],        e.invalid);
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                string t;
                bit    lu;
                t  = (k == 0) ? "a" : "b";
                lu = model_load_use(mv[k], mb[k], in_instr);
                check({t, ".out_valid"}, out_valid[k], mv[k]);
                check({t, ".in_ready"}, in_ready[k], !flush && !lu && (!mv[k] || out_ready));
                check({t, ".hazard_stall"}, hazard_stall[k], in_valid && lu);
                check({t, ".illegal_count"}, (k == 0) ? 32'(cnt_a) : 32'(cnt_b), exp_count(k));
                if (mv[k] || mrst[k]) check_bundle(t, k, mb[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with EX draining; wait (bounded) through stalls.
    task automatic push(input logic [31:0] ins);
        int waited = 0;
        set_in(1'b1, ins, 1'b1, 1'b0);
        #1;
        while (!in_ready[0] && waited < 8) begin
            tick();
            waited++;
        end
        if (!in_ready[0]) begin
            n_vec++; n_miss++;
            $display("FAIL push_timeout: in_ready stuck at 0 for 0x%08h", ins);
        end
        tick();
    endtask

    localparam logic [31:0] I_ADD    = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] I_LW5    = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] I_ADD6   = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] I_SH_BAD = 32'h0020B023;  // store func3=011
    localparam logic [31:0] I_MUL    = 32'h022083B3;  // mul x7,x1,x2
    localparam logic [31:0] I_SW     = 32'h0020A223;  // sw  x2,4(x1)
    localparam logic [31:0] I_SW5    = 32'h0050A023;  // sw  x5,0(x1)

    logic [31:0] illegal_ops [6] = '{32'h00000000, 32'h00009067, 32'h00002063,
                                     32'h00003003, 32'h40001013, 32'h40001033};
    logic [31:0] legal_ops [12] = '{32'h123452B7, 32'h00001117, 32'h008000EF, 32'h000080E7,
                                    32'h00208463, 32'h00008183, 32'h0000D183, 32'h40005013,
                                    32'h40000033, 32'h00000013, 32'h0000A003, 32'h00000333};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst.out_valid",  out_valid[0], 0);
        check("rst.store_type", out_mem_store_type[0], 2'b11);
        check("rst.count",      cnt_a, 0);
        check("rst.in_ready",   in_ready[0], 1);

        // ADD after reset appears one edge later
        set_in(1'b1, I_ADD, 1'b1, 1'b0); tick();
        check("add.out_valid", out_valid[0], 1);
        check("add.rd",        out_rd[0], 3);
        check("add.wb_reg",    out_wb_reg_file[0], 1);
        check("add.alu_src",   out_alu_src[0], 0);
        check("add.invalid",   out_invalid[0], 0);

        // load-use: LW x5 then ADD x6,x5,x2 -> one bubble
        set_in(1'b1, I_LW5, 1'b1, 1'b0); tick();
        check("lw.wb_load", out_wb_load[0], 1);
        set_in(1'b1, I_ADD6, 1'b1, 1'b0); #1;
        check("lu.hazard_stall", hazard_stall[0], 1);
        check("lu.in_ready",     in_ready[0], 0);
        tick();
        check("lu.bubble",       out_valid[0], 0);
        check("lu.ready_again",  in_ready[0], 1);
        tick();
        check("lu.add_valid",    out_valid[0], 1);
        check("lu.add_rd",       out_rd[0], 6);

        // illegal store size
        set_in(1'b1, I_SH_BAD, 1'b1, 1'b0); tick();
        check("sh.invalid",    out_invalid[0], 1);
        check("sh.mem_write",  out_mem_write[0], 0);
        check("sh.store_type", out_mem_store_type[0], 2'b11);
        check("sh.count_pre",  cnt_a, 0);

        // MUL: legal on a, illegal on b; SH retires on this edge
        set_in(1'b1, I_MUL, 1'b1, 1'b0); tick();
        check("sh.count_post", cnt_a, CNT_ON ? 1 : 0);
        check("mul.a_m_type",  out_m_type[0], 1);
        check("mul.a_wb_reg",  out_wb_reg_file[0], 1);
        check("mul.b_invalid", out_invalid[1], 1);
        check("mul.b_m_type",  out_m_type[1], 0);

        foreach (illegal_ops[i]) push(illegal_ops[i]);
        set_in(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("cnt.a_seven", cnt_a, CNT_ON ? 7 : 0);
        check("cnt.b_sat",   cnt_b, CNT_ON ? 3 : 0);

        foreach (legal_ops[i]) push(legal_ops[i]);
        push(I_LW5);
        push(I_SW5);  // rs2 dependency stalls one cycle inside push
        set_in(1'b0, 32'h0, 1'b1, 1'b0); tick();

        // EX back-pressure holds SW stable, then flush discards it
        push(I_SW);
        set_in(1'b1, I_ADD, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold.out_valid",  out_valid[0], 1);
            check("hold.mem_write",  out_mem_write[0], 1);
            check("hold.store_type", out_mem_store_type[0], 2'b10);
            check("hold.in_ready",   in_ready[0], 0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1); tick();
        check("flush.out_valid", out_valid[0], 0);
        check("flush.count",     cnt_a, CNT_ON ? 7 : 0);

        // a flushed illegal bundle is never counted, even with out_ready high
        push(32'h00000000);
        set_in(1'b0, 32'h0, 1'b0, 1'b0); tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b1); tick();
        check("flush_ill.count", cnt_a, CNT_ON ? 7 : 0);

        // reset in the middle of a load-use stall
        push(I_LW5);
        set_in(1'b1, I_ADD6, 1'b0, 1'b0); tick();
        check("rst_mid.stall", hazard_stall[0], 1);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("rst_mid.out_valid",  out_valid[0], 0);
        check("rst_mid.wb_load",    out_wb_load[0], 0);
        check("rst_mid.store_type", out_mem_store_type[0], 2'b11);
        check("rst_mid.count",      cnt_a, 0);
        check("rst_mid.hazard",     hazard_stall[0], 0);

        push(I_ADD);
        set_in(1'b0, 32'h0, 1'b1, 1'b0); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
